// File: rtl/fire_expand_pkg.sv
// Shared defaults, lane-vector type and done-FSM states for the fire-module
// expand accumulator.
package fire_expand_pkg;

   localparam int LANES_DEF  = 4;
   localparam int DATA_W_DEF = 16;
   localparam int OUT_W_DEF  = 8;
   localparam int ADDR_W_DEF = 11;

   typedef logic [LANES_DEF-1:0][DATA_W_DEF-1:0] lane_vec_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } done_state_e;

endpackage

// File: rtl/expand_accum_ram.sv
// Simple dual-port accumulation buffer: one synchronous read port and one
// synchronous write port; a same-address read returns the old word.
module expand_accum_ram #(
   parameter int ADDR_W = 11,
   parameter int WIDTH  = 64
) (
   input  logic              clk_i,
   input  logic              rd_en_i,
   input  logic [ADDR_W-1:0] rd_addr_i,
   output logic [WIDTH-1:0]  rd_data_o,
   input  logic              wr_en_i,
   input  logic [ADDR_W-1:0] wr_addr_i,
   input  logic [WIDTH-1:0]  wr_data_i
);

   logic [WIDTH-1:0] mem_q [2**ADDR_W];
   logic [WIDTH-1:0] rd_data_q;

   always_ff @(posedge clk_i) begin
      if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
      if (rd_en_i) begin
         rd_data_q <= mem_q[rd_addr_i];
      end
   end

   assign rd_data_o = rd_data_q;

endmodule

// File: rtl/expand_accum_ctrl.sv
// Expand partial-sum accumulator: read-modify-write across kernel depth with
// ReLU/requantised output. Define ACCUM_SAT_EN for saturating accumulation.
module expand_accum_ctrl
   import fire_expand_pkg::*;
#(
   parameter int LANES  = LANES_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int OUT_W  = OUT_W_DEF,
   parameter int SHIFT  = 8,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic                    clk_i,
   input  logic                    rst_n_i,
   input  logic                    start_i,
   input  logic [ADDR_W-1:0]       layer_end_addr_i,
   input  logic                    first_layer_flag_i,
   input  logic                    last_layer_flag_i,
   input  logic                    fire_end_flag_i,
   input  logic                    expand_flag_i,
   input  logic [LANES*DATA_W-1:0] conv_data_i,
   output logic                    layer_done_flag_o,
   output logic                    out_valid_o,
   output logic [LANES*OUT_W-1:0]  out_data_o,
   output logic                    done_o
);

   localparam int VEC_W = LANES * DATA_W;
   localparam logic [DATA_W-1:0] S_MAX   = {1'b0, {(DATA_W-1){1'b1}}};
   localparam logic [DATA_W-1:0] S_MIN   = {1'b1, {(DATA_W-1){1'b0}}};
   localparam logic [DATA_W-1:0] OUT_MAX = {{(DATA_W-OUT_W){1'b0}}, {OUT_W{1'b1}}};

   logic                   beat, wrap, wr_en;
   logic [VEC_W-1:0]       ram_rdata, sum_vec;
   logic [LANES*OUT_W-1:0] out_vec;
   logic [DATA_W-1:0]      lane_a, lane_b, lane_s, lane_relu, lane_shr;

   logic [ADDR_W-1:0] r_addr_q, r_addr_d;
   logic              layer_done_q, layer_done_d;
   logic              s1_valid_q, s1_valid_d, s1_first_q, s1_first_d, s1_last_q, s1_last_d;
   logic              s1_byp_q, s1_byp_d;
   logic [ADDR_W-1:0] s1_addr_q, s1_addr_d;
   logic [VEC_W-1:0]  s1_data_q, s1_data_d, s1_byp_data_q, s1_byp_data_d;
   logic              s2_valid_q, s2_valid_d, s2_first_q, s2_first_d, s2_last_q, s2_last_d;
   logic [ADDR_W-1:0] s2_addr_q, s2_addr_d;
   logic [VEC_W-1:0]  s2_data_q, s2_data_d, s2_prev_q, s2_prev_d;
   logic              out_valid_q, out_valid_d;
   logic [LANES*OUT_W-1:0] out_data_q, out_data_d;
   done_state_e       state_q, state_d;

   // start_i outranks a coincident beat, so it never reaches the pipeline
   assign beat  = expand_flag_i && !start_i;
   assign wrap  = beat && (r_addr_q == layer_end_addr_i);
   assign wr_en = s2_valid_q && !start_i;

   expand_accum_ram #(
      .ADDR_W (ADDR_W),
      .WIDTH  (VEC_W)
   ) u_ram (
      .clk_i     (clk_i),
      .rd_en_i   (beat),
      .rd_addr_i (r_addr_q),
      .rd_data_o (ram_rdata),
      .wr_en_i   (wr_en),
      .wr_addr_i (s2_addr_q),
      .wr_data_i (sum_vec)
   );

   always_comb begin
      sum_vec   = '0;
      out_vec   = '0;
      lane_a    = '0;
      lane_b    = '0;
      lane_s    = '0;
      lane_relu = '0;
      lane_shr  = '0;
      for (int l = 0; l < LANES; l++) begin
         lane_a = s2_data_q[l*DATA_W +: DATA_W];
         lane_b = s2_prev_q[l*DATA_W +: DATA_W];
         lane_s = lane_a + lane_b;
`ifdef ACCUM_SAT_EN
         if ((lane_a[DATA_W-1] == lane_b[DATA_W-1]) && (lane_s[DATA_W-1] != lane_a[DATA_W-1])) begin
            lane_s = lane_a[DATA_W-1] ? S_MIN : S_MAX;
         end
`endif
         if (s2_first_q) begin
            lane_s = lane_a;
         end
         lane_relu = lane_s[DATA_W-1] ? '0 : lane_s;
         lane_shr  = lane_relu >> SHIFT;
         sum_vec[l*DATA_W +: DATA_W] = lane_s;
         out_vec[l*OUT_W +: OUT_W]   = (lane_shr > OUT_MAX) ? {OUT_W{1'b1}} : lane_shr[OUT_W-1:0];
      end
   end

   // Bypass: S0 catches a write sitting in S2 now; S1 catches the beat ahead
   // of it once that beat's sum is formed in S2.
   always_comb begin
      r_addr_d     = r_addr_q;
      layer_done_d = 1'b0;
      if (start_i) begin
         r_addr_d = '0;
      end else if (beat) begin
         r_addr_d     = wrap ? '0 : r_addr_q + 1'b1;
         layer_done_d = wrap;
      end

      s1_valid_d    = beat;
      s1_addr_d     = r_addr_q;
      s1_data_d     = conv_data_i;
      s1_first_d    = first_layer_flag_i;
      s1_last_d     = last_layer_flag_i;
      s1_byp_d      = beat && s2_valid_q && (s2_addr_q == r_addr_q);
      s1_byp_data_d = sum_vec;

      s2_valid_d = s1_valid_q && !start_i;
      s2_addr_d  = s1_addr_q;
      s2_data_d  = s1_data_q;
      s2_first_d = s1_first_q;
      s2_last_d  = s1_last_q;
      if (s2_valid_q && (s2_addr_q == s1_addr_q)) begin
         s2_prev_d = sum_vec;
      end else if (s1_byp_q) begin
         s2_prev_d = s1_byp_data_q;
      end else begin
         s2_prev_d = ram_rdata;
      end

      out_valid_d = s2_valid_q && s2_last_q && !start_i;
      out_data_d  = out_valid_d ? out_vec : out_data_q;
   end

   always_comb begin
      state_d = state_q;
      if (start_i) begin
         state_d = RUN;
      end else begin
         case (state_q)
            RUN:     if (wrap && last_layer_flag_i && fire_end_flag_i) state_d = DRAIN;
            DRAIN:   if (!s1_valid_q && !s2_valid_q) state_d = DONE;
            default: state_d = state_q;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_addr_q      <= '0;
         layer_done_q  <= 1'b0;
         s1_valid_q    <= 1'b0;
         s1_addr_q     <= '0;
         s1_data_q     <= '0;
         s1_first_q    <= 1'b0;
         s1_last_q     <= 1'b0;
         s1_byp_q      <= 1'b0;
         s1_byp_data_q <= '0;
         s2_valid_q    <= 1'b0;
         s2_addr_q     <= '0;
         s2_data_q     <= '0;
         s2_first_q    <= 1'b0;
         s2_last_q     <= 1'b0;
         s2_prev_q     <= '0;
         out_valid_q   <= 1'b0;
         out_data_q    <= '0;
         state_q       <= IDLE;
      end else begin
         r_addr_q      <= r_addr_d;
         layer_done_q  <= layer_done_d;
         s1_valid_q    <= s1_valid_d;
         s1_addr_q     <= s1_addr_d;
         s1_data_q     <= s1_data_d;
         s1_first_q    <= s1_first_d;
         s1_last_q     <= s1_last_d;
         s1_byp_q      <= s1_byp_d;
         s1_byp_data_q <= s1_byp_data_d;
         s2_valid_q    <= s2_valid_d;
         s2_addr_q     <= s2_addr_d;
         s2_data_q     <= s2_data_d;
         s2_first_q    <= s2_first_d;
         s2_last_q     <= s2_last_d;
         s2_prev_q     <= s2_prev_d;
         out_valid_q   <= out_valid_d;
         out_data_q    <= out_data_d;
         state_q       <= state_d;
      end
   end

   assign layer_done_flag_o = layer_done_q;
   assign out_valid_o       = out_valid_q;
   assign out_data_o        = out_data_q;
   assign done_o            = (state_q == DONE);

endmodule
